// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the instruction cache
// (client 0) and the data cache (client 1). A granted client owns the bus
// for its whole transaction: request, write data beats, or the full read
// response burst. Ties are broken round-robin.

`ifndef MEM_READ
`define MEM_READ  13'h1100
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 13'h0100
`endif

module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ic_reqcyc,
    output logic                      ic_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] ic_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
    output logic                      ic_respcyc,
    input  logic                      ic_respack,
    output logic [BUS_DATA_WIDTH-1:0] ic_resp,
    output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,

    input  logic                      dc_reqcyc,
    output logic                      dc_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] dc_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
    output logic                      dc_respcyc,
    input  logic                      dc_respack,
    output logic [BUS_DATA_WIDTH-1:0] dc_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dc_resptag,

    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0]         LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_WRITE = BUS_TAG_WIDTH'(`MEM_WRITE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WDATA,
        S_RESP
    } state_t;

    state_t           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             prio_reg, prio_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    // Client-indexed views so the per-client logic can be generated.
    logic [1:0]                cli_reqcyc;
    logic [1:0]                cli_respack;
    logic [1:0]                cli_reqack;
    logic [1:0]                cli_respcyc;
    logic [BUS_DATA_WIDTH-1:0] cli_req    [2];
    logic [BUS_TAG_WIDTH-1:0]  cli_reqtag [2];

    assign cli_reqcyc    = {dc_reqcyc, ic_reqcyc};
    assign cli_respack   = {dc_respack, ic_respack};
    assign cli_req[0]    = ic_req;
    assign cli_req[1]    = dc_req;
    assign cli_reqtag[0] = ic_reqtag;
    assign cli_reqtag[1] = dc_reqtag;

    assign ic_reqack  = cli_reqack[0];
    assign dc_reqack  = cli_reqack[1];
    assign ic_respcyc = cli_respcyc[0];
    assign dc_respcyc = cli_respcyc[1];

    // Response data and tag are broadcast; only respcyc is steered.
    assign ic_resp    = bus_resp;
    assign dc_resp    = bus_resp;
    assign ic_resptag = bus_resptag;
    assign dc_resptag = bus_resptag;

    // Signals of whichever client currently owns the bus.
    logic                      own_reqcyc;
    logic                      own_respack;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;

    assign own_reqcyc  = cli_reqcyc[owner_reg];
    assign own_respack = cli_respack[owner_reg];
    assign own_req     = cli_req[owner_reg];
    assign own_reqtag  = cli_reqtag[owner_reg];

    logic req_phase;
    logic resp_phase;

    // Steer acks and response valid only to the owning client.
    for (genvar gi = 0; gi < 2; gi++) begin : g_client
        assign cli_reqack[gi]  = req_phase  && (owner_reg == 1'(gi)) && bus_reqack;
        assign cli_respcyc[gi] = resp_phase && (owner_reg == 1'(gi)) && bus_respcyc;
    end

    // State, ownership, priority and beat counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            owner_reg    <= 1'b0;
            prio_reg     <= 1'b0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            prio_reg     <= prio_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Next-state logic and bus-side outputs.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        prio_next     = prio_reg;
        beat_cnt_next = beat_cnt_reg;
        bus_reqcyc    = 1'b0;
        bus_req       = '0;
        bus_reqtag    = '0;
        bus_respack   = 1'b0;
        req_phase     = 1'b0;
        resp_phase    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // Stale beats (e.g. after a reset mid-burst) are swallowed here.
                bus_respack = bus_respcyc;
                if (|cli_reqcyc) begin
                    state_next    = S_REQ;
                    beat_cnt_next = '0;
                    owner_next    = (&cli_reqcyc) ? prio_reg : cli_reqcyc[1];
                end
            end

            S_REQ: begin
                req_phase  = 1'b1;
                bus_reqcyc = own_reqcyc;
                bus_req    = own_req;
                bus_reqtag = own_reqtag;
                if (!own_reqcyc) begin
                    // Request withdrawn before acceptance: no service, prio kept.
                    state_next = S_IDLE;
                end else if (bus_reqack) begin
                    beat_cnt_next = '0;
                    state_next    = (own_reqtag == TAG_WRITE) ? S_WDATA : S_RESP;
                end
            end

            S_WDATA: begin
                req_phase  = 1'b1;
                bus_reqcyc = own_reqcyc;
                bus_req    = own_req;
                bus_reqtag = own_reqtag;
                if (own_reqcyc && bus_reqack) begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        state_next    = S_IDLE;
                        prio_next     = ~owner_reg;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end

            S_RESP: begin
                resp_phase  = 1'b1;
                bus_respack = own_respack;
                if (bus_respcyc && own_respack) begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        state_next    = S_IDLE;
                        prio_next     = ~owner_reg;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus randomized
// transactions, checked against a transaction-level model of the grant
// order (least recently served client wins a tie) and beat counts.

`ifndef MEM_READ
`define MEM_READ  13'h1100
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 13'h0100
`endif

module tb_mem_bus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;
    localparam logic [TW-1:0] RD = TW'(`MEM_READ);
    localparam logic [TW-1:0] WR = TW'(`MEM_WRITE);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [1:0]    c_reqcyc  = '0;
    logic [1:0]    c_respack = '0;
    logic [DW-1:0] c_req    [2];
    logic [TW-1:0] c_reqtag [2];

    logic          ic_reqack, dc_reqack, ic_respcyc, dc_respcyc;
    logic [DW-1:0] ic_resp, dc_resp;
    logic [TW-1:0] ic_resptag, dc_resptag;

    logic          bus_reqcyc, bus_respack;
    logic          bus_reqack  = 1'b0;
    logic          bus_respcyc = 1'b0;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic [DW-1:0] bus_resp    = '0;
    logic [TW-1:0] bus_resptag = '0;

    logic [1:0] o_reqack;
    logic [1:0] o_respcyc;
    assign o_reqack  = {dc_reqack, ic_reqack};
    assign o_respcyc = {dc_respcyc, ic_respcyc};

    mem_bus_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .BEATS          (BEATS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ic_reqcyc   (c_reqcyc[0]),
        .ic_reqack   (ic_reqack),
        .ic_req      (c_req[0]),
        .ic_reqtag   (c_reqtag[0]),
        .ic_respcyc  (ic_respcyc),
        .ic_respack  (c_respack[0]),
        .ic_resp     (ic_resp),
        .ic_resptag  (ic_resptag),
        .dc_reqcyc   (c_reqcyc[1]),
        .dc_reqack   (dc_reqack),
        .dc_req      (c_req[1]),
        .dc_reqtag   (c_reqtag[1]),
        .dc_respcyc  (dc_respcyc),
        .dc_respack  (c_respack[1]),
        .dc_resp     (dc_resp),
        .dc_resptag  (dc_resptag),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: which client was served last (1 after reset so icache wins a tie).
    int            last_served = 1;
    logic [DW-1:0] t_addr  [2];
    bit            t_write [2];
    logic [DW-1:0] t_wdata [2][BEATS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick();
        if (c_reqcyc == 2'b11) return 1 - last_served;
        return c_reqcyc[1] ? 1 : 0;
    endfunction

    task automatic post(input int c, input bit wr, input logic [DW-1:0] addr, input bit seq);
        t_addr[c]  = addr;
        t_write[c] = wr;
        for (int b = 0; b < BEATS; b++)
            t_wdata[c][b] = seq ? DW'(b) : {$urandom, $urandom};
        c_reqcyc[c] = 1'b1;
        c_req[c]    = addr;
        c_reqtag[c] = wr ? WR : RD;
    endtask

    // One cycle in which the arbiter must be idle: stray beat is drained, nothing granted.
    task automatic idle_cycle();
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        bus_reqack  = 1'b1;
        @(negedge clk);
        chk("idle_reqcyc", 64'(bus_reqcyc), 64'(0));
        chk("idle_req", bus_req, 64'(0));
        chk("idle_drain", 64'(bus_respack), 64'(1));
        chk("idle_route", 64'({o_respcyc, o_reqack}), 64'(0));
        tick();
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b0;
    endtask

    // Serve the transaction the model says wins, starting in an idle cycle.
    task automatic serve(input int stall_len, input int stall_at, input int hold_n,
                         input int abort_after);
        int w, d, hs, cyc, stalled, held;
        bit v, a;
        logic [DW-1:0] rdata;
        w = pick();
        idle_cycle();
        d = $urandom_range(0, 2);
        for (int k = 0; k <= d; k++) begin
            bus_reqack  = (k == d);
            bus_respcyc = 1'($urandom % 2);
            @(negedge clk);
            chk("req_cyc", 64'(bus_reqcyc), 64'(1));
            chk("req_addr", bus_req, t_addr[w]);
            chk("req_tag", 64'(bus_reqtag), 64'(t_write[w] ? WR : RD));
            chk("req_ack", 64'(o_reqack), (k == d) ? 64'(1 << w) : 64'(0));
            chk("req_stray", 64'({bus_respack, o_respcyc}), 64'(0));
            tick();
        end
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        if (t_write[w]) begin
            for (int b = 0; b < BEATS; b++) begin
                c_req[w] = t_wdata[w][b];
                d = $urandom_range(0, 2);
                for (int k = 0; k <= d; k++) begin
                    bus_reqack  = (k == d);
                    bus_respcyc = 1'($urandom % 2);
                    @(negedge clk);
                    chk("wr_cyc", 64'(bus_reqcyc), 64'(1));
                    chk("wr_data", bus_req, t_wdata[w][b]);
                    chk("wr_ack", 64'(o_reqack), (k == d) ? 64'(1 << w) : 64'(0));
                    chk("wr_stray", 64'({bus_respack, o_respcyc}), 64'(0));
                    tick();
                end
            end
            c_reqcyc[w] = 1'b0;
        end else begin
            c_reqcyc[w] = 1'b0;
            hs = 0; cyc = 0; stalled = 0; held = 0;
            while (hs < BEATS && cyc < 200) begin
                if (hs == stall_at && stalled < stall_len) begin
                    v = 1'b0;
                    stalled++;
                end else begin
                    v = ($urandom % 4) != 0;
                end
                if (v && held < hold_n) begin
                    a = 1'b0;
                    held++;
                end else begin
                    a = ($urandom % 5) != 0;
                end
                rdata             = {$urandom, $urandom};
                bus_respcyc       = v;
                bus_resp          = rdata;
                bus_resptag       = RD;
                c_respack[w]      = a;
                c_respack[1 - w]  = 1'($urandom % 2);
                bus_reqack        = 1'($urandom % 2);
                @(negedge clk);
                chk("resp_route", 64'(o_respcyc), v ? 64'(1 << w) : 64'(0));
                chk("resp_ack", 64'(bus_respack), 64'(a));
                chk("resp_data_ic", ic_resp, rdata);
                chk("resp_data_dc", dc_resp, rdata);
                chk("resp_tag", 64'(ic_resptag), 64'(RD));
                chk("resp_quiet", 64'({bus_reqcyc, o_reqack}), 64'(0));
                if (v && a) hs++;
                cyc++;
                tick();
                if (abort_after > 0 && hs == abort_after) begin
                    bus_respcyc = 1'b0;
                    bus_reqack  = 1'b0;
                    c_respack   = '0;
                    return;
                end
            end
            chk("resp_beats", 64'(hs), 64'(BEATS));
        end
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b0;
        c_respack   = '0;
        last_served = w;
    endtask

    int m;

    initial begin
        for (int c = 0; c < 2; c++) begin
            c_req[c]    = '0;
            c_reqtag[c] = '0;
        end
        // Reset and check quiescent outputs.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_bus", 64'({bus_reqcyc, bus_respack}), 64'(0));
        chk("rst_client", 64'({o_reqack, o_respcyc}), 64'(0));
        tick();

        // icache read of 0x1000, then a tie must go to dcache (prio=1).
        post(0, 1'b0, 64'h1000, 1'b0);
        serve(0, 0, 0, 0);
        post(0, 1'b0, 64'h1100, 1'b0);
        post(1, 1'b0, 64'h2200, 1'b0);
        serve(0, 0, 0, 0);
        serve(0, 0, 0, 0);
        idle_cycle();

        // After reset a tie goes icache, dcache, and the next tie icache again.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_served = 1;
        post(0, 1'b0, 64'h3000, 1'b0);
        post(1, 1'b0, 64'h4000, 1'b0);
        serve(0, 0, 0, 0);
        serve(0, 0, 0, 0);
        post(0, 1'b0, 64'h3040, 1'b0);
        post(1, 1'b0, 64'h4040, 1'b0);
        serve(0, 0, 0, 0);
        serve(0, 0, 0, 0);

        // dcache write of 0x2040 with data beats 0..7.
        post(1, 1'b1, 64'h2040, 1'b1);
        serve(0, 0, 0, 0);
        idle_cycle();

        // Memory stalls 5 cycles mid-burst; owner withholds respack for 2 beats.
        post(0, 1'b0, 64'h5000, 1'b0);
        serve(5, 3, 2, 0);
        idle_cycle();

        // Reset after the 3rd of 8 read beats; remaining 5 beats are drained.
        post(0, 1'b0, 64'h6000, 1'b0);
        serve(0, 0, 0, 3);
        reset = 1'b1;
        c_respack = 2'b01;
        tick();
        reset = 1'b0;
        c_respack = '0;
        last_served = 1;
        @(negedge clk);
        chk("abort_bus", 64'({bus_reqcyc, bus_respack}), 64'(0));
        chk("abort_client", 64'({o_reqack, o_respcyc}), 64'(0));
        tick();
        for (int b = 0; b < 5; b++) begin
            bus_respcyc  = 1'b1;
            bus_resp     = {$urandom, $urandom};
            c_respack    = 2'b11;
            @(negedge clk);
            chk("drain_ack", 64'(bus_respack), 64'(1));
            chk("drain_route", 64'({o_respcyc, bus_reqcyc}), 64'(0));
            tick();
        end
        bus_respcyc = 1'b0;
        c_respack   = '0;

        // Owner withdraws in REQ: back to IDLE, prio untouched (dcache still favoured).
        post(0, 1'b0, 64'h7000, 1'b0);
        serve(0, 0, 0, 0);
        post(1, 1'b0, 64'h7100, 1'b0);
        idle_cycle();
        @(negedge clk);
        chk("drop_grant", 64'(bus_reqcyc), 64'(1));
        chk("drop_addr", bus_req, 64'h7100);
        tick();
        c_reqcyc[1] = 1'b0;
        @(negedge clk);
        chk("drop_cyc", 64'({bus_reqcyc, o_reqack}), 64'(0));
        tick();
        idle_cycle();
        post(0, 1'b0, 64'h7200, 1'b0);
        post(1, 1'b0, 64'h7300, 1'b0);
        serve(0, 0, 0, 0);
        serve(0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int t = 0; t < 12; t++) begin
            m = $urandom_range(1, 3);
            for (int c = 0; c < 2; c++)
                if (m[c]) post(c, 1'($urandom % 2), {$urandom, $urandom} & ~64'h3f, 1'b0);
            while (c_reqcyc != 2'b00)
                serve($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 2), 0);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
